// File: rtl/game_pkg.sv
// Shared game constants and the pulse stretcher state encoding.
// Default timings assume the 10 MHz board clock; override per game here.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } stretch_state_t;

   localparam int DEF_ON_CYCLES   = 5_000_000;
   localparam int DEF_GAP_CYCLES  = 2_500_000;
   localparam int DEF_MAX_PENDING = 7;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter. Simultaneous inc and dec cancel, so the count
// never wraps in either direction.
module sat_counter #(
   parameter int MAX = 7
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_inc,
   input  logic                         i_dec,
   output logic [$clog2(MAX+1)-1:0]     o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int W = $clog2(MAX + 1);

   logic [W-1:0] r_cnt;
   logic         w_full;
   logic         w_empty;

   assign w_full  = (r_cnt == W'(MAX));
   assign w_empty = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_inc && !i_dec && !w_full)
         r_cnt <= r_cnt + W'(1);
      else if (i_dec && !i_inc && !w_empty)
         r_cnt <= r_cnt - W'(1);
   end

   assign o_count = r_cnt;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/pulse_stretch.sv
// Stretches one-cycle event strobes into ON-high / GAP-low level phases.
// Event backlog counter is built only when PULSE_STRETCH_QUEUE_EN is defined.
module pulse_stretch
   import game_pkg::*;
#(
   parameter int ON_CYCLES   = DEF_ON_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int MAX_PENDING = DEF_MAX_PENDING
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               pulse_in,
   output logic                               level_out,
   output logic                               busy,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               overflow
);

   localparam int CNT_MAX = max2(ON_CYCLES, GAP_CYCLES);
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

   stretch_state_t r_state, w_nstate;
   logic [CW-1:0]  r_cnt, w_ncnt;
   logic           r_level, r_busy;
   logic           w_pend_nz;

`ifdef PULSE_STRETCH_QUEUE_EN
   logic w_inc, w_dec, w_full, w_empty;
   logic r_ovf;
`endif

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
`ifdef PULSE_STRETCH_QUEUE_EN
      w_inc    = 1'b0;
      w_dec    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (pulse_in) begin
               w_nstate = ON;
               w_ncnt   = ON_LD;
            end
         end
         ON: begin
`ifdef PULSE_STRETCH_QUEUE_EN
            w_inc = pulse_in;
`endif
            if (r_cnt == '0) begin
               w_nstate = GAP;
               w_ncnt   = GAP_LD;
            end else begin
               w_ncnt = r_cnt - CW'(1);
            end
         end
         GAP: begin
            if (r_cnt != '0) begin
               w_ncnt = r_cnt - CW'(1);
`ifdef PULSE_STRETCH_QUEUE_EN
               w_inc  = pulse_in;
`endif
            end else if (w_pend_nz || pulse_in) begin
               // A backlog entry wins the restart; a same-cycle pulse then
               // takes its place in the backlog instead.
               w_nstate = ON;
               w_ncnt   = ON_LD;
`ifdef PULSE_STRETCH_QUEUE_EN
               w_dec    = w_pend_nz;
               w_inc    = pulse_in & w_pend_nz;
`endif
            end else begin
               w_nstate = IDLE;
            end
         end
         default: begin
            w_nstate = IDLE;
            w_ncnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_level <= (w_nstate == ON);
         r_busy  <= (w_nstate != IDLE);
      end
   end

   assign level_out = r_level;
   assign busy      = r_busy;

`ifdef PULSE_STRETCH_QUEUE_EN
   sat_counter #(
      .MAX (MAX_PENDING)
   ) u_pending (
      .clk     (clk),
      .rst_n   (reset),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .o_count (pending),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_pend_nz = ~w_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_ovf <= 1'b0;
      else
         r_ovf <= w_inc & w_full & ~w_dec;
   end

   assign overflow = r_ovf;
`else
   assign w_pend_nz = 1'b0;
   assign pending   = '0;
   assign overflow  = 1'b0;
`endif

endmodule
